// File: rtl/rr_arbiter_4req.sv
// rr_arbiter_4req: 4-requester round-robin arbiter with a registered one-hot
// grant released by a valid/ready handshake. Priority rotates to the requester
// after the one just served on every completed handshake.
// Optional feature macro: RR_ARB_LOCK_EN (burst lock, up to MAX_BURST beats
// per held grant while the granted requester keeps its request high).
module rr_arbiter_4req #(
  parameter logic [1:0] RESET_PTR = 2'd0,
  parameter int         MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       gnt_ready,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Burst counter holds 0..MAX_BURST-1.
  localparam int              BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);

  state_t      state_reg, state_next;
  logic [1:0]  ptr_reg, ptr_next;
  logic [3:0]  gnt_reg, gnt_next;
  logic        gnt_valid_reg, gnt_valid_next;

  logic        handshake;
  logic [1:0]  granted_idx;
  logic [1:0]  rotated_ptr;
  logic [1:0]  search_base;
  logic [3:0]  rot_req;
  logic        found;
  logic [1:0]  win_offset;
  logic [1:0]  winner_idx;
  logic [3:0]  winner_onehot;
  logic [BW-1:0] burst_cnt;
  logic        hold;

  assign handshake   = gnt_valid_reg & gnt_ready;
  assign rotated_ptr = granted_idx + 2'd1;
  // The search in a handshake cycle already uses the rotated pointer so that
  // back-to-back grants need no bubble.
  assign search_base = handshake ? rotated_ptr : ptr_reg;
  assign found       = |req;
  assign winner_idx  = search_base + win_offset;

  // Encode the currently held one-hot grant back to an index.
  always_comb begin
    granted_idx = 2'd0;
    case (gnt_reg)
      4'b0010: granted_idx = 2'd1;
      4'b0100: granted_idx = 2'd2;
      4'b1000: granted_idx = 2'd3;
      default: granted_idx = 2'd0;
    endcase
  end

  // Rotate the request vector so that bit 0 is the highest-priority slot,
  // and build the winner one-hot from the winning index.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rot_req[gi]       = req[search_base + 2'(gi)];
      assign winner_onehot[gi] = found && (winner_idx == 2'(gi));
    end
  endgenerate

  // First set bit of the rotated request vector wins.
  always_comb begin
    win_offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) win_offset = 2'(i);
    end
  end

`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;

  assign burst_cnt = burst_cnt_reg;

  // Count beats of a held grant; any rotating handshake (including the one
  // that drops back to IDLE) restarts the count.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (hold)           burst_cnt_next = burst_cnt_reg + BW'(1);
    else if (handshake) burst_cnt_next = '0;
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_reg <= '0;
    else        burst_cnt_reg <= burst_cnt_next;
  end
`else
  localparam bit LOCK_EN = 1'b0;
  assign burst_cnt = '0;
`endif

  // Keep the same grant on this handshake instead of rotating (burst lock).
  assign hold = LOCK_EN & handshake & req[granted_idx] & (burst_cnt < BURST_LAST);

  // Next-state and next-grant logic.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next       = winner_onehot;
          gnt_valid_next = 1'b1;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (handshake && !hold) begin
          ptr_next = rotated_ptr;
          if (found) begin
            gnt_next = winner_onehot;
          end else begin
            gnt_next       = 4'b0000;
            gnt_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = 4'b0000;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= RESET_PTR;
      gnt_reg       <= 4'b0000;
      gnt_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// tb_rr_arbiter_4req: directed vectors with hand-computed expected grants
// for the default build of rr_arbiter_4req.
module tb_rr_arbiter_4req;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       gnt_ready;
  logic [3:0] gnt;
  logic       gnt_valid;

  int n_vectors     = 0;
  int n_miscompares = 0;

  rr_arbiter_4req #(
    .RESET_PTR(2'd0),
    .MAX_BURST(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] exp_gnt, input logic exp_valid);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
  endtask

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rot_seq [0:3];
    rot_seq[0] = 4'b0010;
    rot_seq[1] = 4'b0100;
    rot_seq[2] = 4'b1000;
    rot_seq[3] = 4'b0001;

    rst_n     = 1'b0;
    req       = 4'hF;
    gnt_ready = 1'b0;

    // Reset holds everything off despite all requests high.
    tick();
    tick();
    check_gnt("reset", 4'b0000, 1'b0);

    // First grant one cycle after reset release, from RESET_PTR=0.
    rst_n = 1'b1;
    tick();
    check_gnt("first_grant", 4'b0001, 1'b1);

    // All requesting, ready held: rotate every cycle without gaps.
    gnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_gnt($sformatf("rotate%0d", i), rot_seq[i], 1'b1);
    end

    // Handshake with no requests left: back to IDLE (ptr becomes 1).
    req = 4'b0000;
    tick();
    check_gnt("drain_idle", 4'b0000, 1'b0);

    // Ready while nothing valid is ignored.
    tick();
    check_gnt("ready_ignored", 4'b0000, 1'b0);

    // Grant to requester 2, hold it through ready=0 and request changes.
    req       = 4'b0100;
    gnt_ready = 1'b0;
    tick();
    check_gnt("grant2", 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req = 4'b1011;
      if (i == 3) req = 4'b0000;
      tick();
      check_gnt($sformatf("hold%0d", i), 4'b0100, 1'b1);
    end
    gnt_ready = 1'b1;
    tick();
    check_gnt("release_idle", 4'b0000, 1'b0);

    // From IDLE with ptr=3: scan 3,0,1 -> requester 1.
    req       = 4'b0010;
    gnt_ready = 1'b0;
    tick();
    check_gnt("grant1", 4'b0010, 1'b1);

    // Handshake on 1 rotates ptr to 2; with req=0011 the scan wraps to 0.
    req       = 4'b0011;
    gnt_ready = 1'b1;
    tick();
    check_gnt("wrap_to0", 4'b0001, 1'b1);
    tick();
    check_gnt("alt_a", 4'b0010, 1'b1);
    tick();
    check_gnt("alt_b", 4'b0001, 1'b1);
    tick();
    check_gnt("alt_c", 4'b0010, 1'b1);

    // Sole requester is re-granted on every handshake.
    req = 4'b1000;
    tick();
    check_gnt("sole_a", 4'b1000, 1'b1);
    tick();
    check_gnt("sole_b", 4'b1000, 1'b1);

    // Move the grant to requester 1, then hold it.
    req = 4'b0010;
    tick();
    check_gnt("pre_rst", 4'b0010, 1'b1);
    gnt_ready = 1'b0;
    tick();
    check_gnt("pre_rst_hold", 4'b0010, 1'b1);

    // Asynchronous reset between edges clears the grant immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_gnt("async_rst", 4'b0000, 1'b0);
    tick();
    check_gnt("rst_held", 4'b0000, 1'b0);

    // After reset, ptr=0 again: scan 0,1 -> requester 1.
    rst_n = 1'b1;
    tick();
    check_gnt("post_rst", 4'b0010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
